// File: rtl/psa_pipe.sv
// rtl/psa_pipe.sv - two-stage packed-SIMD lane adder with saturation flags and event counter
module psa_pipe #(
    parameter int LANE_W = 4,
    parameter int LANES  = 4,
    parameter int CNT_W  = 8
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [LANE_W*LANES-1:0]   A,
    input  logic [LANE_W*LANES-1:0]   B,
    input  logic [1:0]                op,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [LANE_W*LANES-1:0]   Sum,
    output logic [LANES-1:0]          sat_flags,
    input  logic                      clr_cnt,
    output logic [CNT_W-1:0]          sat_count
);

    localparam int W = LANE_W * LANES;
    localparam logic [LANE_W-1:0] LANE_MAX = {1'b0, {(LANE_W-1){1'b1}}};
    localparam logic [LANE_W-1:0] LANE_MIN = {1'b1, {(LANE_W-1){1'b0}}};

    logic              s1_valid;
    logic [W-1:0]      s1_a;
    logic [W-1:0]      s1_b;
    logic [1:0]        s1_op;

    logic              s2_valid;
    logic [W-1:0]      s2_sum;
    logic [LANES-1:0]  s2_flags;
    logic [CNT_W-1:0]  cnt;

    logic              s1_load;
    logic              s2_load;
    logic              is_sat;
    logic              is_sub;
    logic [LANE_W:0]   ea;
    logic [LANE_W:0]   eb;
    logic [LANE_W:0]   r;
    logic [W-1:0]      calc_sum;
    logic [LANES-1:0]  calc_flags;

    // S2 takes S1 whenever S2 is empty or its result leaves this cycle;
    // S1 may then refill in the same cycle, so a full pipe streams without a bubble.
    assign s2_load  = s1_valid & (~s2_valid | out_ready);
    assign in_ready = ~s1_valid | s2_load;
    assign s1_load  = in_valid & in_ready;

    // op[1] selects subtract, ops 01 and 10 are the saturating ones.
    assign is_sub = s1_op[1];
    assign is_sat = s1_op[1] ^ s1_op[0];

    // Per-lane arithmetic on sign-extended operands; overflow shows as the top two bits disagreeing.
    always_comb begin
        calc_sum   = '0;
        calc_flags = '0;
        ea         = '0;
        eb         = '0;
        r          = '0;
        for (int i = 0; i < LANES; i++) begin
            ea = {s1_a[i*LANE_W+LANE_W-1], s1_a[i*LANE_W +: LANE_W]};
            eb = {s1_b[i*LANE_W+LANE_W-1], s1_b[i*LANE_W +: LANE_W]};
            r  = is_sub ? (ea - eb) : (ea + eb);
            if (is_sat && (r[LANE_W] != r[LANE_W-1])) begin
                calc_sum[i*LANE_W +: LANE_W] = r[LANE_W] ? LANE_MIN : LANE_MAX;
                calc_flags[i]                = 1'b1;
            end else begin
                calc_sum[i*LANE_W +: LANE_W] = r[LANE_W-1:0];
            end
        end
    end

    // Stage 1: capture operands and op on an input handshake, empty when S2 drains it.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_a     <= '0;
            s1_b     <= '0;
            s1_op    <= '0;
        end else if (s1_load) begin
            s1_valid <= 1'b1;
            s1_a     <= A;
            s1_b     <= B;
            s1_op    <= op;
        end else if (s2_load) begin
            s1_valid <= 1'b0;
        end
    end

    // Stage 2: register lane results; hold them while the consumer stalls.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s2_valid <= 1'b0;
            s2_sum   <= '0;
            s2_flags <= '0;
        end else if (s2_load) begin
            s2_valid <= 1'b1;
            s2_sum   <= calc_sum;
            s2_flags <= calc_flags;
        end else if (out_ready) begin
            s2_valid <= 1'b0;
        end
    end

    // Count delivered results that clamped any lane; clear wins, count sticks at all-ones.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr_cnt) begin
            cnt <= '0;
        end else if (s2_valid && out_ready && (|s2_flags) && (cnt != {CNT_W{1'b1}})) begin
            cnt <= cnt + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    assign out_valid = s2_valid;
    assign Sum       = s2_sum;
    assign sat_flags = s2_flags;
    assign sat_count = cnt;

endmodule

// File: tb/tb_psa_pipe.sv
// tb/tb_psa_pipe.sv - self-checking bench for psa_pipe with lane-arithmetic reference model
module tb_psa_pipe;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        out_ready;
    logic        clr_cnt;
    logic [15:0] A;
    logic [15:0] B;
    logic [1:0]  op;

    logic        in_ready, out_valid;
    logic [15:0] Sum;
    logic [3:0]  sat_flags;
    logic [7:0]  sat_count;

    logic        c2_in_ready, c2_out_valid;
    logic [15:0] c2_sum;
    logic [3:0]  c2_flags;
    logic [1:0]  c2_count;

    logic        w_in_ready, w_out_valid;
    logic [15:0] w_sum;
    logic [1:0]  w_flags;
    logic [7:0]  w_count;

    int checks = 0;
    int errors = 0;
    int delivered = 0;
    int cnt_m = 0;
    int cnt2_m = 0;

    typedef struct packed {
        logic [15:0] s;
        logic [3:0]  f;
    } exp_t;

    exp_t q[$];
    exp_t q8[$];

    logic        prev_hold = 1'b0;
    logic [15:0] prev_sum;
    logic [3:0]  prev_flags;

    always #5 clk = ~clk;

    psa_pipe #(.LANE_W(4), .LANES(4), .CNT_W(8)) u_dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .A(A), .B(B), .op(op), .out_valid(out_valid), .out_ready(out_ready),
        .Sum(Sum), .sat_flags(sat_flags), .clr_cnt(clr_cnt), .sat_count(sat_count)
    );

    psa_pipe #(.LANE_W(4), .LANES(4), .CNT_W(2)) u_c2 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(c2_in_ready),
        .A(A), .B(B), .op(op), .out_valid(c2_out_valid), .out_ready(out_ready),
        .Sum(c2_sum), .sat_flags(c2_flags), .clr_cnt(clr_cnt), .sat_count(c2_count)
    );

    psa_pipe #(.LANE_W(8), .LANES(2), .CNT_W(8)) u_w8 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(w_in_ready),
        .A(A), .B(B), .op(op), .out_valid(w_out_valid), .out_ready(out_ready),
        .Sum(w_sum), .sat_flags(w_flags), .clr_cnt(clr_cnt), .sat_count(w_count)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: lanes as signed integers, plain add/sub, clamp to the lane range.
    function automatic void ref_op(input int lw, input int n, input logic [15:0] a,
                                   input logic [15:0] b, input logic [1:0] o,
                                   output logic [15:0] s, output logic [3:0] f);
        int av, bv, r, mx, mn, mask;
        logic [31:0] acc;
        mask = (1 << lw) - 1;
        mx   = (1 << (lw - 1)) - 1;
        mn   = -(1 << (lw - 1));
        acc  = 0;
        f    = 4'b0;
        for (int i = 0; i < n; i++) begin
            av = int'(a >> (i * lw)) & mask;
            bv = int'(b >> (i * lw)) & mask;
            if (av > mx) av = av - (1 << lw);
            if (bv > mx) bv = bv - (1 << lw);
            r = o[1] ? (av - bv) : (av + bv);
            if (o == 2'b01 || o == 2'b10) begin
                if (r > mx) begin
                    r = mx;
                    f[i] = 1'b1;
                end else if (r < mn) begin
                    r = mn;
                    f[i] = 1'b1;
                end
            end
            acc = acc | (32'(r & mask) << (i * lw));
        end
        s = acc[15:0];
    endfunction

    // Scoreboard: model every accepted input, compare every delivered output, track counters.
    always @(negedge clk) begin
        exp_t e;
        logic [15:0] s;
        logic [3:0]  f;
        logic        inc;
        if (!rst_n) begin
            q.delete();
            q8.delete();
            cnt_m     = 0;
            cnt2_m    = 0;
            prev_hold = 1'b0;
        end else begin
            inc = 1'b0;
            chk("sat_count", sat_count, cnt_m);
            chk("sat_count_cnt2", c2_count, cnt2_m);
            if (prev_hold) begin
                chk("hold_valid", out_valid, 1);
                chk("hold_sum", Sum, prev_sum);
                chk("hold_flags", sat_flags, prev_flags);
            end
            if (out_valid && out_ready) begin
                chk("out_expected", 32'(q.size() != 0), 1);
                if (q.size() != 0) begin
                    e = q.pop_front();
                    chk("out_sum", Sum, e.s);
                    chk("out_flags", sat_flags, e.f);
                    inc = |e.f;
                end
                delivered++;
            end
            if (w_out_valid && out_ready) begin
                chk("w8_out_expected", 32'(q8.size() != 0), 1);
                if (q8.size() != 0) begin
                    e = q8.pop_front();
                    chk("w8_out_sum", w_sum, e.s);
                    chk("w8_out_flags", w_flags, e.f[1:0]);
                end
            end
            if (clr_cnt) begin
                cnt_m  = 0;
                cnt2_m = 0;
            end else if (inc) begin
                if (cnt_m < 255) cnt_m++;
                if (cnt2_m < 3) cnt2_m++;
            end
            if (in_valid && in_ready) begin
                ref_op(4, 4, A, B, op, s, f);
                q.push_back({s, f});
            end
            if (in_valid && w_in_ready) begin
                ref_op(8, 2, A, B, op, s, f);
                q8.push_back({s, f});
            end
            prev_hold  = out_valid & ~out_ready;
            prev_sum   = Sum;
            prev_flags = sat_flags;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_one(input logic [15:0] a, input logic [15:0] b, input logic [1:0] o,
                            input logic [15:0] exp_s, input logic [3:0] exp_f, input string tag);
        in_valid = 1'b1;
        A = a;
        B = b;
        op = o;
        #1;
        chk({tag, "_in_ready"}, in_ready, 1);
        step();
        in_valid = 1'b0;
        chk({tag, "_lat1"}, out_valid, 0);
        step();
        chk({tag, "_valid"}, out_valid, 1);
        chk({tag, "_sum"}, Sum, exp_s);
        chk({tag, "_flags"}, sat_flags, exp_f);
    endtask

    initial begin
        logic [15:0] sa [4];
        logic [15:0] sb [4];
        logic [15:0] e0_s;
        logic [3:0]  e0_f;
        logic        last_acc;
        int          d0;

        sa = '{16'h1234, 16'h5678, 16'h9ABC, 16'hDEF0};
        sb = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; clr_cnt = 1'b0;
        A = '0; B = '0; op = '0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_sum", Sum, 0);
        chk("rst_flags", sat_flags, 0);
        chk("rst_count", sat_count, 0);
        chk("rst_in_ready", in_ready, 1);

        send_one(16'h8888, 16'h8888, 2'b01, 16'h8888, 4'hF, "t1_neg");
        send_one(16'h7777, 16'h7777, 2'b01, 16'h7777, 4'hF, "t1_pos");
        send_one(16'h4444, 16'h4444, 2'b01, 16'h7777, 4'hF, "t1_over");
        send_one(16'h3333, 16'h3333, 2'b01, 16'h6666, 4'h0, "t1_fit");
        step();
        chk("t4_count3", sat_count, 3);
        chk("t4_cnt2_at3", c2_count, 3);

        in_valid = 1'b1; A = 16'h8888; B = 16'h8888; op = 2'b01;
        step();
        in_valid = 1'b0;
        step();
        chk("t4_pending", out_valid, 1);
        clr_cnt = 1'b1;
        step();
        clr_cnt = 1'b0;
        chk("t4_clr_prio", sat_count, 0);
        chk("t4_clr_cnt2", c2_count, 0);

        for (int i = 0; i < 5; i++)
            send_one(16'h8888, 16'h8888, 2'b01, 16'h8888, 4'hF, "t4_ev");
        step();
        chk("t4_count5", sat_count, 5);
        chk("t4_cnt2_hold", c2_count, 3);

        send_one(16'hFFFF, 16'hFFFF, 2'b00, 16'hEEEE, 4'h0, "t2_wadd");
        send_one(16'h0000, 16'h1111, 2'b11, 16'hFFFF, 4'h0, "t2_wsub");
        send_one(16'h8888, 16'h1111, 2'b10, 16'h8888, 4'hF, "t2_ssub_neg");
        send_one(16'h7777, 16'h8888, 2'b10, 16'h7777, 4'hF, "t2_ssub_pos");

        send_one(16'h7F80, 16'h01FF, 2'b01, 16'h708F, 4'b0010, "t6_n4");
        chk("t6_w8_valid", w_out_valid, 1);
        chk("t6_w8_sum", w_sum, 16'h7F80);
        chk("t6_w8_flags", w_flags, 2'b11);
        repeat (2) step();

        ref_op(4, 4, sa[0], sb[0], 2'b01, e0_s, e0_f);
        d0 = delivered;
        op = 2'b01;
        in_valid = 1'b1; A = sa[0]; B = sb[0];
        step();
        A = sa[1]; B = sb[1];
        step();
        chk("t3_first_valid", out_valid, 1);
        out_ready = 1'b0;
        A = sa[2]; B = sb[2];
        #1;
        chk("t3_stall_in_ready", in_ready, 0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("t3_stall_in_ready_hold", in_ready, 0);
            chk("t3_stall_sum", Sum, e0_s);
        end
        out_ready = 1'b1;
        #1;
        chk("t3_resume_in_ready", in_ready, 1);
        step();
        A = sa[3]; B = sb[3];
        step();
        in_valid = 1'b0;
        repeat (3) step();
        chk("t3_delivered", delivered - d0, 4);
        chk("t3_queue_empty", q.size(), 0);

        in_valid = 1'b1; A = 16'h8888; B = 16'h8888; op = 2'b01;
        step();
        A = 16'h7777; B = 16'h7777;
        step();
        in_valid = 1'b0;
        out_ready = 1'b0;
        chk("t5_inflight", out_valid, 1);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        chk("t5_out_valid", out_valid, 0);
        chk("t5_count", sat_count, 0);
        chk("t5_in_ready", in_ready, 1);
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("t5_no_stale", out_valid, 0);
        end

        last_acc = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (!in_valid || last_acc) begin
                in_valid = ($urandom_range(0, 9) < 7);
                A  = 16'($urandom);
                B  = 16'($urandom);
                op = 2'($urandom_range(0, 3));
            end
            out_ready = ($urandom_range(0, 9) < 7);
            clr_cnt   = ($urandom_range(0, 29) == 0);
            @(negedge clk);
            last_acc = in_valid && in_ready;
            step();
        end

        in_valid = 1'b0; out_ready = 1'b1; clr_cnt = 1'b0;
        repeat (4) step();
        chk("drain_empty", q.size(), 0);
        chk("drain_empty_w8", q8.size(), 0);
        chk("drain_idle", out_valid, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
